// File: rtl/cpu_bus_ctrl.sv
// Microstep decoder / bus sequencer: turns the cpu_control state code into registered
// one-hot bus enables and load strobes. Optional watchdog under CPU_BUS_WATCHDOG_EN.
module cpu_bus_ctrl #(
  parameter logic [2:0] IDLE_OE = 3'd7
) (
  input  logic       clk,
  input  logic       reset_cycle,
  input  logic [3:0] state,
  input  logic [7:0] opcode,
  input  logic       flag_zero,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ir_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       reg_oe,
  output logic       reg_ld,
  output logic [2:0] reg_oe_sel,
  output logic [2:0] reg_ld_sel,
  output logic       tmp_ld,
  output logic       tmp_oe,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       out_load,
  output logic       next,
  output logic       halted,
  output logic       fault
);

  localparam logic [3:0] S_FETCH_PC   = 4'd0;
  localparam logic [3:0] S_FETCH_INST = 4'd1;
  localparam logic [3:0] S_LOAD_ADDR  = 4'd2;
  localparam logic [3:0] S_RAM_A      = 4'd3;
  localparam logic [3:0] S_RAM_B      = 4'd4;
  localparam logic [3:0] S_STORE_A    = 4'd5;
  localparam logic [3:0] S_ALU_OP     = 4'd6;
  localparam logic [3:0] S_LDI        = 4'd7;
  localparam logic [3:0] S_MOV_FETCH  = 4'd8;
  localparam logic [3:0] S_MOV_LOAD   = 4'd9;
  localparam logic [3:0] S_MOV_STORE  = 4'd10;
  localparam logic [3:0] S_OUT_A      = 4'd11;
  localparam logic [3:0] S_JUMP       = 4'd12;
  localparam logic [3:0] S_NEXT       = 4'd13;
  localparam logic [3:0] S_HALT       = 4'd14;

  localparam logic [7:0] OP_SUB = 8'h11;
  localparam logic [7:0] OP_JMP = 8'h20;
  localparam logic [7:0] OP_JEZ = 8'h21;
  localparam logic [7:0] OP_JNZ = 8'h22;

  logic       n_pc_inc, n_pc_load, n_mar_load, n_ir_load;
  logic       n_ram_oe, n_ram_we, n_reg_oe, n_reg_ld;
  logic [2:0] n_reg_oe_sel, n_reg_ld_sel;
  logic       n_tmp_ld, n_tmp_oe, n_alu_oe, n_alu_sub, n_out_load, n_next;
  logic       jump_taken;

  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JEZ) && flag_zero) ||
                      ((opcode == OP_JNZ) && !flag_zero);

  // Once halted, decode is suppressed entirely so nothing can disturb the datapath.
  always_comb begin
    n_pc_inc     = 1'b0;
    n_pc_load    = 1'b0;
    n_mar_load   = 1'b0;
    n_ir_load    = 1'b0;
    n_ram_oe     = 1'b0;
    n_ram_we     = 1'b0;
    n_reg_oe     = 1'b0;
    n_reg_ld     = 1'b0;
    n_reg_oe_sel = IDLE_OE;
    n_reg_ld_sel = IDLE_OE;
    n_tmp_ld     = 1'b0;
    n_tmp_oe     = 1'b0;
    n_alu_oe     = 1'b0;
    n_alu_sub    = 1'b0;
    n_out_load   = 1'b0;
    n_next       = 1'b0;
    if (!halted) begin
      case (state)
        S_FETCH_PC: begin
          n_pc_inc   = 1'b1;
          n_mar_load = 1'b1;
        end
        S_FETCH_INST: begin
          n_ram_oe  = 1'b1;
          n_ir_load = 1'b1;
        end
        S_LOAD_ADDR: begin
          n_ram_oe   = 1'b1;
          n_mar_load = 1'b1;
          n_pc_inc   = 1'b1;
        end
        S_RAM_A: begin
          n_ram_oe     = 1'b1;
          n_reg_ld     = 1'b1;
          n_reg_ld_sel = 3'd0;
        end
        S_RAM_B: begin
          n_ram_oe     = 1'b1;
          n_reg_ld     = 1'b1;
          n_reg_ld_sel = 3'd1;
        end
        S_STORE_A: begin
          n_reg_oe     = 1'b1;
          n_reg_oe_sel = 3'd0;
          n_ram_we     = 1'b1;
        end
        S_ALU_OP: begin
          n_alu_oe     = 1'b1;
          n_reg_ld     = 1'b1;
          n_reg_ld_sel = 3'd0;
          n_alu_sub    = (opcode == OP_SUB);
        end
        S_LDI: begin
          n_ram_oe     = 1'b1;
          n_reg_ld     = 1'b1;
          n_reg_ld_sel = opcode[2:0];
          n_pc_inc     = 1'b1;
        end
        S_MOV_FETCH: begin
          n_reg_oe     = 1'b1;
          n_reg_oe_sel = opcode[2:0];
          n_tmp_ld     = 1'b1;
        end
        S_MOV_LOAD: begin
          n_tmp_oe = 1'b1;
        end
        S_MOV_STORE: begin
          n_tmp_oe     = 1'b1;
          n_reg_ld     = 1'b1;
          n_reg_ld_sel = opcode[5:3];
        end
        S_OUT_A: begin
          n_reg_oe     = 1'b1;
          n_reg_oe_sel = 3'd0;
          n_out_load   = 1'b1;
        end
        S_JUMP: begin
          n_ram_oe  = 1'b1;
          n_pc_load = jump_taken;
          n_pc_inc  = !jump_taken;
        end
        S_NEXT: begin
          n_next = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      mar_load   <= 1'b0;
      ir_load    <= 1'b0;
      ram_oe     <= 1'b0;
      ram_we     <= 1'b0;
      reg_oe     <= 1'b0;
      reg_ld     <= 1'b0;
      reg_oe_sel <= IDLE_OE;
      reg_ld_sel <= IDLE_OE;
      tmp_ld     <= 1'b0;
      tmp_oe     <= 1'b0;
      alu_oe     <= 1'b0;
      alu_sub    <= 1'b0;
      out_load   <= 1'b0;
      next       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      pc_inc     <= n_pc_inc;
      pc_load    <= n_pc_load;
      mar_load   <= n_mar_load;
      ir_load    <= n_ir_load;
      ram_oe     <= n_ram_oe;
      ram_we     <= n_ram_we;
      reg_oe     <= n_reg_oe;
      reg_ld     <= n_reg_ld;
      reg_oe_sel <= n_reg_oe_sel;
      reg_ld_sel <= n_reg_ld_sel;
      tmp_ld     <= n_tmp_ld;
      tmp_oe     <= n_tmp_oe;
      alu_oe     <= n_alu_oe;
      alu_sub    <= n_alu_sub;
      out_load   <= n_out_load;
      next       <= n_next;
      if (state == S_HALT) halted <= 1'b1;
    end
  end

`ifdef CPU_BUS_WATCHDOG_EN
  // Counts microsteps since the last FETCH_PC; a ninth step means a runaway instruction.
  logic [3:0] wd_cnt;
  logic [3:0] wd_cnt_n;

  always_comb begin
    wd_cnt_n = wd_cnt;
    if (state == S_FETCH_PC) wd_cnt_n = 4'd0;
    else if (wd_cnt != 4'd15) wd_cnt_n = wd_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      wd_cnt <= 4'd0;
      fault  <= 1'b0;
    end else if (!halted) begin
      wd_cnt <= wd_cnt_n;
      if (wd_cnt_n == 4'd9) fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Randomized scoreboard bench for cpu_bus_ctrl: a step-level reference model pushes the
// expected output vector per sampled state; a monitor pops and compares after each edge.
module tb_cpu_bus_ctrl;

  localparam logic [2:0] IDLE = 3'd7;

  localparam logic [3:0] S_FETCH_PC   = 4'd0;
  localparam logic [3:0] S_FETCH_INST = 4'd1;
  localparam logic [3:0] S_LOAD_ADDR  = 4'd2;
  localparam logic [3:0] S_RAM_A      = 4'd3;
  localparam logic [3:0] S_RAM_B      = 4'd4;
  localparam logic [3:0] S_STORE_A    = 4'd5;
  localparam logic [3:0] S_ALU_OP     = 4'd6;
  localparam logic [3:0] S_LDI        = 4'd7;
  localparam logic [3:0] S_MOV_FETCH  = 4'd8;
  localparam logic [3:0] S_MOV_LOAD   = 4'd9;
  localparam logic [3:0] S_MOV_STORE  = 4'd10;
  localparam logic [3:0] S_OUT_A      = 4'd11;
  localparam logic [3:0] S_JUMP       = 4'd12;
  localparam logic [3:0] S_NEXT       = 4'd13;
  localparam logic [3:0] S_HALT       = 4'd14;
  localparam logic [3:0] S_BAD        = 4'd15;

  localparam logic [7:0] OP_SUB = 8'h11;
  localparam logic [7:0] OP_JMP = 8'h20;
  localparam logic [7:0] OP_JEZ = 8'h21;
  localparam logic [7:0] OP_JNZ = 8'h22;

  typedef struct packed {
    logic       pc_inc, pc_load, mar_load, ir_load, ram_oe, ram_we, reg_oe, reg_ld;
    logic [2:0] reg_oe_sel, reg_ld_sel;
    logic       tmp_ld, tmp_oe, alu_oe, alu_sub, out_load, next, halted, fault;
  } bus_t;

  logic       clk;
  logic       reset_cycle;
  logic [3:0] state;
  logic [7:0] opcode;
  logic       flag_zero;
  logic       pc_inc, pc_load, mar_load, ir_load, ram_oe, ram_we, reg_oe, reg_ld;
  logic [2:0] reg_oe_sel, reg_ld_sel;
  logic       tmp_ld, tmp_oe, alu_oe, alu_sub, out_load, next, halted, fault;

  logic [$bits(bus_t)-1:0] exp_q[$];
  int total;
  int bad;

  // Model state: halt flag, steps since the last FETCH_PC, sticky fault.
  bit m_halted;
  int m_steps;
  bit m_fault;

  cpu_bus_ctrl #(.IDLE_OE(IDLE)) dut (
    .clk(clk), .reset_cycle(reset_cycle), .state(state), .opcode(opcode),
    .flag_zero(flag_zero), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ir_load(ir_load), .ram_oe(ram_oe), .ram_we(ram_we), .reg_oe(reg_oe), .reg_ld(reg_ld),
    .reg_oe_sel(reg_oe_sel), .reg_ld_sel(reg_ld_sel), .tmp_ld(tmp_ld), .tmp_oe(tmp_oe),
    .alu_oe(alu_oe), .alu_sub(alu_sub), .out_load(out_load), .next(next),
    .halted(halted), .fault(fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bus_t dut_vec();
    bus_t v;
    v = '{pc_inc, pc_load, mar_load, ir_load, ram_oe, ram_we, reg_oe, reg_ld,
          reg_oe_sel, reg_ld_sel, tmp_ld, tmp_oe, alu_oe, alu_sub, out_load, next,
          halted, fault};
    return v;
  endfunction

  function automatic bus_t idle_vec();
    bus_t v;
    v = '0;
    v.reg_oe_sel = IDLE;
    v.reg_ld_sel = IDLE;
    return v;
  endfunction

  task automatic check(input string name, input bus_t got, input bus_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (state=%0d opcode=%h)", name, got, want, state, opcode);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step(input logic [3:0] st, input logic [7:0] op, input logic fz,
                            output bus_t e);
    bit taken;
    e = idle_vec();
    taken = (op == OP_JMP) || (op == OP_JEZ && fz) || (op == OP_JNZ && !fz);
    if (!m_halted) begin
      case (st)
        S_FETCH_PC:   begin e.pc_inc = 1; e.mar_load = 1; end
        S_FETCH_INST: begin e.ram_oe = 1; e.ir_load = 1; end
        S_LOAD_ADDR:  begin e.ram_oe = 1; e.mar_load = 1; e.pc_inc = 1; end
        S_RAM_A:      begin e.ram_oe = 1; e.reg_ld = 1; e.reg_ld_sel = 0; end
        S_RAM_B:      begin e.ram_oe = 1; e.reg_ld = 1; e.reg_ld_sel = 1; end
        S_STORE_A:    begin e.reg_oe = 1; e.reg_oe_sel = 0; e.ram_we = 1; end
        S_ALU_OP:     begin e.alu_oe = 1; e.reg_ld = 1; e.reg_ld_sel = 0;
                            e.alu_sub = (op == OP_SUB); end
        S_LDI:        begin e.ram_oe = 1; e.reg_ld = 1; e.reg_ld_sel = op[2:0];
                            e.pc_inc = 1; end
        S_MOV_FETCH:  begin e.reg_oe = 1; e.reg_oe_sel = op[2:0]; e.tmp_ld = 1; end
        S_MOV_LOAD:   begin e.tmp_oe = 1; end
        S_MOV_STORE:  begin e.tmp_oe = 1; e.reg_ld = 1; e.reg_ld_sel = op[5:3]; end
        S_OUT_A:      begin e.reg_oe = 1; e.reg_oe_sel = 0; e.out_load = 1; end
        S_JUMP:       begin e.ram_oe = 1; e.pc_load = taken; e.pc_inc = !taken; end
        S_NEXT:       begin e.next = 1; end
        default:      begin end
      endcase
`ifdef CPU_BUS_WATCHDOG_EN
      m_steps = (st == S_FETCH_PC) ? 0 : m_steps + 1;
      if (m_steps >= 9) m_fault = 1;
`endif
    end
    if (st == S_HALT) m_halted = 1;
    e.halted = m_halted;
    e.fault  = m_fault;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: present inputs, record the expected response, hold one cycle.
  task automatic drive(input logic [3:0] st, input logic [7:0] op, input logic fz);
    bus_t e;
    state = st;
    opcode = op;
    flag_zero = fz;
    model_step(st, op, fz, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without waiting for clk.
  task automatic pulse_reset(input string name);
    reset_cycle = 1'b1;
    #1;
    check(name, dut_vec(), idle_vec());
    m_halted = 0;
    m_steps = 0;
    m_fault = 0;
    @(negedge clk);
    reset_cycle = 1'b0;
  endtask

  task automatic random_step();
    int r;
    logic [3:0] st;
    logic [7:0] op;
    r = $urandom_range(0, 99);
    if (r < 3) st = S_HALT;
    else if (r < 18) st = S_FETCH_PC;
    else begin
      st = 4'($urandom_range(0, 15));
      if (st == S_HALT) st = S_BAD;
    end
    case ($urandom_range(0, 4))
      0: op = OP_SUB;
      1: op = OP_JMP;
      2: op = OP_JEZ;
      3: op = OP_JNZ;
      default: op = 8'($urandom_range(0, 255));
    endcase
    drive(st, op, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_cycle && exp_q.size() > 0) begin
        bus_t want;
        want = exp_q.pop_front();
        check("decode", dut_vec(), want);
        total++;
        if ($countones({ram_oe, reg_oe, tmp_oe, alu_oe}) > 1) begin
          bad++;
          $display("FAIL bus_driver: got %b want at most one set",
                   {ram_oe, reg_oe, tmp_oe, alu_oe});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad = 0;
    m_halted = 0;
    m_steps = 0;
    m_fault = 0;
    reset_cycle = 1'b1;
    state = S_BAD;
    opcode = 8'h00;
    flag_zero = 1'b0;
    #7;
    check("reset_values", dut_vec(), idle_vec());
    @(negedge clk);
    reset_cycle = 1'b0;

    // Reset in the middle of an LDI, then a clean fetch.
    drive(S_FETCH_PC, 8'h00, 0);
    drive(S_LDI, 8'b00_010_101, 0);
    pulse_reset("reset_mid_ldi");
    drive(S_FETCH_PC, 8'h00, 0);
    drive(S_LDI, 8'b00_010_101, 0);
    drive(S_FETCH_PC, 8'h00, 0);

    // MOV r3 <- r2.
    drive(S_FETCH_INST, 8'b10_011_010, 0);
    drive(S_MOV_FETCH, 8'b10_011_010, 0);
    drive(S_MOV_LOAD, 8'b10_011_010, 0);
    drive(S_MOV_STORE, 8'b10_011_010, 0);
    drive(S_NEXT, 8'b10_011_010, 0);
    drive(S_NEXT, 8'b10_011_010, 0);

    // Conditional jumps both ways, plus ALU subtract select.
    drive(S_FETCH_PC, OP_JEZ, 1);
    drive(S_JUMP, OP_JEZ, 1);
    drive(S_JUMP, OP_JEZ, 0);
    drive(S_JUMP, OP_JNZ, 1);
    drive(S_JUMP, OP_JNZ, 0);
    drive(S_JUMP, OP_JMP, 0);
    drive(S_ALU_OP, OP_SUB, 0);
    drive(S_ALU_OP, 8'h10, 0);
    drive(S_BAD, OP_SUB, 1);

    // Long instruction: nine steps without FETCH_PC.
    drive(S_FETCH_PC, 8'h00, 0);
    for (int i = 0; i < 10; i++) drive(S_MOV_LOAD, 8'h00, 0);
    drive(S_FETCH_PC, 8'h00, 0);
    drive(S_OUT_A, 8'h00, 0);

    // Halt then keep feeding states; everything must stay quiet.
    pulse_reset("reset_before_halt");
    drive(S_FETCH_PC, 8'h00, 0);
    drive(S_HALT, 8'h00, 0);
    drive(S_FETCH_PC, 8'h00, 0);
    drive(S_NEXT, 8'h00, 0);
    drive(S_LDI, 8'h05, 0);
    drive(S_NEXT, 8'h00, 0);
    pulse_reset("reset_after_halt");

    // Random segments, each ending with a reset to escape any halt.
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 40; i++) random_step();
      pulse_reset("reset_random");
    end

    drive(S_FETCH_PC, 8'h00, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
